// File: rtl/dco_clock_mp_pkg.sv
// rtl/dco_clock_mp_pkg.sv - shared widths, state enum and PWL constants for the RX DCO clocks
package dco_clock_mp_pkg;

    localparam int N_PHASES_DEF     = 4;
    localparam int DCO_CODE_WIDTH   = 8;
    localparam int DCO_PERIOD_WIDTH = 16;
    localparam int RX_JITTER_WIDTH  = 4;
    localparam int TIME_WIDTH       = 32;
    localparam int LFSR_WIDTH       = 16;

    typedef logic [DCO_CODE_WIDTH-1:0]   dco_code_t;
    typedef logic [DCO_PERIOD_WIDTH-1:0] dco_period_t;
    typedef logic [TIME_WIDTH-1:0]       time_t;

    typedef enum logic [1:0] {
        CLK_IDLE  = 2'd0,
        CLK_PRIME = 2'd1,
        CLK_RUN   = 2'd2,
        CLK_PARK  = 2'd3
    } clk_state_e;

    // Steep segment up to the knee, shallow segment above it, floored at PMIN.
    localparam int RX_DCO_P0   = 1000;
    localparam int RX_DCO_S0   = 20;
    localparam int RX_DCO_KNEE = 48;
    localparam int RX_DCO_S1   = 1;
    localparam int RX_DCO_PMIN = 4;

    function automatic int rx_dco_period(input int code);
        int p;
        if (code <= RX_DCO_KNEE) begin
            p = RX_DCO_P0 - RX_DCO_S0 * code;
        end else begin
            p = RX_DCO_P0 - RX_DCO_S0 * RX_DCO_KNEE - RX_DCO_S1 * (code - RX_DCO_KNEE);
        end
        if (p < RX_DCO_PMIN) begin
            p = RX_DCO_PMIN;
        end
        return p;
    endfunction

endpackage

// File: rtl/lfsr_jitter.sv
// rtl/lfsr_jitter.sv - seeded Fibonacci LFSR producing a sign-extended per-edge jitter value
module lfsr_jitter
    import dco_clock_mp_pkg::*;
#(
    parameter int                    JITTER_WIDTH = RX_JITTER_WIDTH,
    parameter int                    OUT_WIDTH    = DCO_PERIOD_WIDTH + 1,
    parameter logic [LFSR_WIDTH-1:0] SEED         = 16'd3
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        advance_i,
    output logic signed [OUT_WIDTH-1:0] jitter_o
);

    logic [LFSR_WIDTH-1:0] lfsr_q;
    logic [LFSR_WIDTH-1:0] lfsr_d;
    logic                  feedback;

    // x^16 + x^14 + x^13 + x^11: maximal length, never reaches zero from a nonzero seed.
    assign feedback = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign lfsr_d   = advance_i ? {lfsr_q[LFSR_WIDTH-2:0], feedback} : lfsr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    if (JITTER_WIDTH == 0) begin : g_none
        assign jitter_o = '0;
    end else begin : g_jit
        logic signed [JITTER_WIDTH-1:0] raw;
        assign raw      = lfsr_q[JITTER_WIDTH-1:0];
        assign jitter_o = OUT_WIDTH'(raw);
    end

endmodule

// File: rtl/pwl.sv
// rtl/pwl.sv - piecewise-linear DCO code to period lookup with a fixed pipeline latency
module pwl
    import dco_clock_mp_pkg::*;
#(
    parameter int CODE_WIDTH   = DCO_CODE_WIDTH,
    parameter int PERIOD_WIDTH = DCO_PERIOD_WIDTH,
    parameter int LAT          = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [CODE_WIDTH-1:0]   code_i,
    output logic [PERIOD_WIDTH-1:0] period_o
);

    logic [PERIOD_WIDTH-1:0] period_raw;

    always_comb begin
        period_raw = PERIOD_WIDTH'(rx_dco_period(int'(code_i)));
    end

    if (LAT == 0) begin : g_comb
        logic unused_clk;
        assign unused_clk = clk_i ^ rst_ni;
        assign period_o   = period_raw;
    end else begin : g_pipe
        logic [PERIOD_WIDTH-1:0] pipe_q [LAT];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int i = 0; i < LAT; i++) begin
                    pipe_q[i] <= '0;
                end
            end else begin
                pipe_q[0] <= period_raw;
                for (int i = 1; i < LAT; i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
        end

        assign period_o = pipe_q[LAT-1];
    end

endmodule

// File: rtl/dco_clock_mp.sv
// rtl/dco_clock_mp.sv - multi-phase gateable DCO clock emitting emulated phase-edge timestamps
module dco_clock_mp
    import dco_clock_mp_pkg::*;
#(
    parameter int N_PHASES     = N_PHASES_DEF,
    parameter int CODE_WIDTH   = DCO_CODE_WIDTH,
    parameter int PERIOD_WIDTH = DCO_PERIOD_WIDTH,
    parameter int JITTER_WIDTH = RX_JITTER_WIDTH,
    parameter int CODE_MIN     = 0,
    parameter int CODE_MAX     = 2**CODE_WIDTH - 1,
    parameter int CODE_INIT    = 0,
    parameter int SLEW         = 1,
    parameter int PWL_LAT      = 1,
    parameter int LFSR_INIT    = 3
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          en_i,
    input  logic [TIME_WIDTH-1:0]         time_next_i,
    input  logic [CODE_WIDTH-1:0]         code_i,
    output logic [TIME_WIDTH-1:0]         time_clock_o,
    output logic                          time_eq_o,
    output logic [N_PHASES-1:0]           cke_out_o,
    output logic [$clog2(N_PHASES)-1:0]   phase_o,
    output logic [CODE_WIDTH-1:0]         code_applied_o,
    output logic                          running_o
);

    localparam int PH_W  = $clog2(N_PHASES);
    localparam int CNT_W = $clog2(PWL_LAT + 2);
    localparam logic [CODE_WIDTH-1:0] SLEW_C     = CODE_WIDTH'(SLEW);
    localparam logic [PH_W-1:0]       LAST_PHASE = PH_W'(N_PHASES - 1);

    clk_state_e              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [TIME_WIDTH-1:0]   time_clock_q, time_clock_d;
    logic [PH_W-1:0]         phase_q, phase_d;
    logic [CODE_WIDTH-1:0]   code_q, code_d;
    logic [PERIOD_WIDTH-1:0] period_q, period_d;

    logic [CODE_WIDTH-1:0]     code_tgt;
    logic [CODE_WIDTH-1:0]     code_slewed;
    logic [PERIOD_WIDTH-1:0]   lookup;
    logic [PERIOD_WIDTH-1:0]   period_eff;
    logic [PERIOD_WIDTH-1:0]   step;
    logic [PERIOD_WIDTH-1:0]   inc;
    logic signed [PERIOD_WIDTH:0] jitter;
    logic signed [PERIOD_WIDTH:0] step_jit;
    logic                      time_eq;
    logic                      phase0_edge;

    pwl #(
        .CODE_WIDTH   (CODE_WIDTH),
        .PERIOD_WIDTH (PERIOD_WIDTH),
        .LAT          (PWL_LAT)
    ) u_pwl (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .code_i   (code_q),
        .period_o (lookup)
    );

    lfsr_jitter #(
        .JITTER_WIDTH (JITTER_WIDTH),
        .OUT_WIDTH    (PERIOD_WIDTH + 1),
        .SEED         (LFSR_WIDTH'(LFSR_INIT))
    ) u_jitter (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .advance_i (time_eq),
        .jitter_o  (jitter)
    );

    assign time_eq     = (state_q == CLK_RUN) && (time_next_i == time_clock_q);
    assign phase0_edge = time_eq && (phase_q == '0);

    always_comb begin
        code_tgt = code_i;
        if (int'(code_i) < CODE_MIN) begin
            code_tgt = CODE_WIDTH'(CODE_MIN);
        end else if (int'(code_i) > CODE_MAX) begin
            code_tgt = CODE_WIDTH'(CODE_MAX);
        end

        code_slewed = code_tgt;
        if (code_tgt > code_q) begin
            if ((code_tgt - code_q) > SLEW_C) begin
                code_slewed = code_q + SLEW_C;
            end
        end else if ((code_q - code_tgt) > SLEW_C) begin
            code_slewed = code_q - SLEW_C;
        end
    end

    // The whole period is spaced by the period latched on its own phase-0 edge.
    always_comb begin
        period_eff = phase0_edge ? lookup : period_q;
        step       = period_eff >> PH_W;
        step_jit   = $signed({1'b0, step}) + jitter;
        if (step_jit[PERIOD_WIDTH] || (step_jit == '0)) begin
            inc = PERIOD_WIDTH'(1);
        end else begin
            inc = step_jit[PERIOD_WIDTH-1:0];
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        time_clock_d = time_clock_q;
        phase_d      = phase_q;
        code_d       = code_q;
        period_d     = period_q;

        unique case (state_q)
            CLK_IDLE, CLK_PARK: begin
                time_clock_d = '1;
                if (en_i) begin
                    state_d = CLK_PRIME;
                    cnt_d   = CNT_W'(PWL_LAT + 1);
                end
            end
            CLK_PRIME: begin
                cnt_d = cnt_q - 1'b1;
                if (!en_i) begin
                    state_d = CLK_IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    period_d     = lookup;
                    time_clock_d = time_next_i + TIME_WIDTH'(lookup >> PH_W);
                    phase_d      = '0;
                    state_d      = CLK_RUN;
                end
            end
            CLK_RUN: begin
                if (time_eq) begin
                    time_clock_d = time_clock_q + TIME_WIDTH'(inc);
                    phase_d      = phase_q + 1'b1;
                    if (phase0_edge) begin
                        code_d   = code_slewed;
                        period_d = lookup;
                    end
                    // A stop request only takes effect on the wrap, so no period is cut short.
                    if (!en_i && (phase_q == LAST_PHASE)) begin
                        state_d      = CLK_PARK;
                        time_clock_d = '1;
                        phase_d      = '0;
                    end
                end
            end
            default: begin
                state_d = CLK_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= CLK_IDLE;
            cnt_q        <= '0;
            time_clock_q <= '1;
            phase_q      <= '0;
            code_q       <= CODE_WIDTH'(CODE_INIT);
            period_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            time_clock_q <= time_clock_d;
            phase_q      <= phase_d;
            code_q       <= code_d;
            period_q     <= period_d;
        end
    end

    assign time_clock_o   = time_clock_q;
    assign time_eq_o      = time_eq;
    assign cke_out_o      = time_eq ? (N_PHASES'(1) << phase_q) : '0;
    assign phase_o        = phase_q;
    assign code_applied_o = code_q;
    assign running_o      = (state_q == CLK_RUN);

endmodule

// File: tb/tb_dco_clock_mp.sv
// tb/tb_dco_clock_mp.sv - scoreboard bench for dco_clock_mp
module tb_dco_clock_mp;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [7:0]  code;
    logic [31:0] t_idle;
    logic [31:0] time_next;
    logic [31:0] time_clock;
    logic        time_eq;
    logic [3:0]  cke;
    logic [1:0]  phase;
    logic [7:0]  code_applied;
    logic        running;

    logic        rst_j_n;
    logic        en_j;
    logic [7:0]  code_j;
    logic [31:0] time_next_j;
    logic [31:0] tc_j;
    logic        time_eq_j;
    logic [3:0]  cke_j;
    logic [1:0]  phase_j;
    logic [7:0]  ca_j;
    logic        running_j;

    int n_tests = 0;
    int n_fail  = 0;
    int n_strobes = 0;
    int jn = 0;
    logic [31:0] jprev;
    logic [31:0] jmax = 0;

    typedef struct {
        logic [31:0] t;
        logic [3:0]  cke;
        logic [1:0]  ph;
        logic [7:0]  ca;
    } exp_t;
    exp_t sb_q[$];

    int s12_t[24]  = '{200, 400, 600, 800, 1000, 1200, 1400, 1600, 1800, 1995, 2190, 2385,
                       2580, 2770, 2960, 3150, 3340, 3525, 3710, 3895, 4080, 4260, 4440, 4620};
    int s12_ca[24] = '{10, 10, 10, 10, 10, 11, 11, 11, 11, 12, 12, 12,
                       12, 13, 13, 13, 13, 14, 14, 14, 14, 14, 14, 14};

    assign time_next   = (time_clock == 32'hFFFF_FFFF) ? t_idle : time_clock;
    assign time_next_j = (tc_j == 32'hFFFF_FFFF) ? 32'd0 : tc_j;

    dco_clock_mp #(
        .N_PHASES(4), .CODE_WIDTH(8), .PERIOD_WIDTH(16), .JITTER_WIDTH(0),
        .CODE_MIN(0), .CODE_MAX(40), .CODE_INIT(10), .SLEW(1), .PWL_LAT(1), .LFSR_INIT(3)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .time_next_i(time_next), .code_i(code),
        .time_clock_o(time_clock), .time_eq_o(time_eq), .cke_out_o(cke), .phase_o(phase),
        .code_applied_o(code_applied), .running_o(running)
    );

    dco_clock_mp #(
        .N_PHASES(4), .CODE_WIDTH(8), .PERIOD_WIDTH(16), .JITTER_WIDTH(8),
        .CODE_MIN(84), .CODE_MAX(84), .CODE_INIT(84), .SLEW(1), .PWL_LAT(1), .LFSR_INIT(3)
    ) dut_j (
        .clk_i(clk), .rst_ni(rst_j_n), .en_i(en_j), .time_next_i(time_next_j), .code_i(code_j),
        .time_clock_o(tc_j), .time_eq_o(time_eq_j), .cke_out_o(cke_j), .phase_o(phase_j),
        .code_applied_o(ca_j), .running_o(running_j)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push(input logic [31:0] t, input int ph, input logic [7:0] ca);
        exp_t e;
        e.t   = t;
        e.cke = 4'(1 << ph);
        e.ph  = 2'(ph);
        e.ca  = ca;
        sb_q.push_back(e);
    endtask

    task automatic wait_strobes(input int n);
        int k = 0;
        while (n_strobes < n && k < 1000) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (n_strobes < n) check("strobe_timeout", n_strobes, n);
    endtask

    task automatic prime_latency(input string name);
        int cyc = 0;
        while (!running && cyc < 10) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check(name, cyc, 3);
    endtask

    // Main clock monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && cke != 4'b0) begin
            n_strobes++;
            if (sb_q.size() == 0) begin
                check("unexpected_strobe", {28'b0, cke}, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("edge_time", time_clock, e.t);
                check("edge_cke", {28'b0, cke}, {28'b0, e.cke});
                check("edge_phase", {30'b0, phase}, {30'b0, e.ph});
                check("edge_code", {24'b0, code_applied}, {24'b0, e.ca});
                check("edge_eq", {31'b0, time_eq}, 32'd1);
            end
        end
    end

    // Jittered clock monitor: successive edge timestamps must strictly increase.
    always @(negedge clk) begin
        if (rst_j_n && time_eq_j && jn < 10000) begin
            if (jn > 0) begin
                check("jit_monotonic", {31'b0, (tc_j > jprev)}, 32'd1);
                if (tc_j - jprev > jmax) jmax = tc_j - jprev;
            end
            jprev = tc_j;
            jn++;
        end
    end

    initial begin
        int t;
        int ca;
        int s;
        int nca;
        int k;

        clk = 0; rst_n = 0; rst_j_n = 0; en = 0; en_j = 0;
        code = 8'd10; code_j = 8'd84; t_idle = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1; rst_j_n = 1; en_j = 1;
        #1;
        check("rst_time_clock", time_clock, 32'hFFFF_FFFF);
        check("rst_phase", {30'b0, phase}, 32'd0);
        check("rst_code", {24'b0, code_applied}, 32'd10);
        check("rst_running", {31'b0, running}, 32'd0);
        check("rst_cke", {28'b0, cke}, 32'd0);
        check("rst_time_eq", {31'b0, time_eq}, 32'd0);

        for (int i = 0; i < 24; i++) push(s12_t[i], i % 4, 8'(s12_ca[i]));
        t = 4800; ca = 14;
        for (int p = 0; p < 31; p++) begin
            s   = (1000 - 20 * ca) / 4;
            nca = (ca < 40) ? ca + 1 : 40;
            push(t, 0, 8'(ca));
            push(t + s, 1, 8'(nca));
            push(t + 2 * s, 2, 8'(nca));
            push(t + 3 * s, 3, 8'(nca));
            t  = t + 4 * s;
            ca = nca;
        end

        en = 1;
        prime_latency("prime_latency");
        wait_strobes(4);
        code = 8'd14;
        wait_strobes(24);
        code = 8'd200;
        wait_strobes(146);
        en = 0;
        t_idle = 32'd10000;
        wait_strobes(148);
        @(posedge clk);
        #1;
        check("park_running", {31'b0, running}, 32'd0);
        check("park_time_clock", time_clock, 32'hFFFF_FFFF);
        check("park_time_eq", {31'b0, time_eq}, 32'd0);
        check("park_code_sat", {24'b0, code_applied}, 32'd40);
        repeat (4) @(negedge clk);
        #1;
        check("park_strobes", n_strobes, 148);

        push(32'd10050, 0, 8'd40);
        push(32'd10100, 1, 8'd40);
        push(32'd10150, 2, 8'd40);
        en = 1;
        prime_latency("restart_latency");
        wait_strobes(151);
        rst_n = 0;
        en = 0;
        #1;
        check("arst_cke", {28'b0, cke}, 32'd0);
        check("arst_time_clock", time_clock, 32'hFFFF_FFFF);
        check("arst_time_eq", {31'b0, time_eq}, 32'd0);
        check("arst_running", {31'b0, running}, 32'd0);
        @(negedge clk);
        rst_n = 1;
        #1;
        check("arst_code_init", {24'b0, code_applied}, 32'd10);
        repeat (5) @(negedge clk);
        #1;
        check("sb_drained", sb_q.size(), 0);
        check("final_strobes", n_strobes, 151);

        k = 0;
        while (jn < 10000 && k < 15000) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("jit_edges", jn, 10000);
        check("jit_spread", {31'b0, (jmax > 32'd1)}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
